hello_cpu_0_oci_trace_monitor: RTL and testbench
================================================

Name: hello_cpu_0_oci_trace_monitor

Overview:
- Parametrised successor to the passive OCI test-bench hook.
- Captures OCI data-capture-trigger (DCT) words into a show-ahead FIFO and checks the DCT sequence count for gaps.
- On test_ending, stops capture, drains the FIFO through a valid/ready read port, then asserts test_has_ended.
- Sits beside the CPU OCI block in simulation and debug builds.

Parameters:
- DATA_W, 30: width of dct_buffer and rd_data.
- CNT_W, 4: width of dct_count and the expected-sequence register.
- DEPTH, 16: FIFO entries; must be a power of two, minimum 2.
- LVL_W, $clog2(DEPTH)+1: width of fill_level (derived; not overridden).
- DROP_W, 8: width of the saturating drop counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- dct_buffer  in  DATA_W  DCT data word.
- dct_count  in  CNT_W  sender's sequence number for dct_buffer.
- dct_valid  in  1  dct_buffer/dct_count valid this cycle; no back-pressure.
- test_ending  in  1  pulse or level; requests end of capture.
- rd_data  out  DATA_W  FIFO head word.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  consumer accepts rd_data when rd_valid=1.
- fill_level  out  LVL_W  current number of FIFO entries, 0..DEPTH.
- overflow  out  1  sticky: at least one DCT word was dropped.
- drop_count  out  DROP_W  dropped words, saturating at all-ones.
- count_mismatch  out  1  sticky: a sequence gap was seen.
- mismatch_seen  out  CNT_W  dct_count value at the first mismatch.
- test_has_ended  out  1  capture ended and FIFO fully drained.

Behaviour:
- Reset (reset_n=0 at an edge): state=CAPTURE, FIFO empty, exp_seq=0. All outputs 0 (rd_data=0, fill_level=0). Reset mid-drain discards FIFO contents, and reset takes precedence over every other input.
- States:
  - CAPTURE: writes enabled.
  - DRAIN: writes disabled, reads continue.
  - DONE: terminal; held until reset.
- Transitions:
  - CAPTURE -> DRAIN when test_ending=1. A dct_valid in the same cycle is still processed.
  - DRAIN -> DONE at the edge where the FIFO is empty after that cycle's pop.
  - test_ending is ignored in DRAIN and DONE.
- test_has_ended is registered: it goes 1 in the cycle the state becomes DONE and stays 1 until reset.
- Push: occurs when dct_valid=1 and state=CAPTURE and (FIFO not full, or a pop happens this cycle).
  - Full with a simultaneous pop: the push is accepted and fill_level stays at DEPTH.
- Drop: occurs when dct_valid=1 in CAPTURE and the word is not pushed.
  - overflow<=1.
  - drop_count increments, saturating at 2^DROP_W-1.
  - dct_valid in DRAIN or DONE is neither pushed nor counted as a drop.
- Pop: occurs when rd_valid=1 and rd_ready=1.
  - rd_ready while empty has no effect.
- Show-ahead read: rd_data always equals the head entry.
  - A word pushed into an empty FIFO appears on rd_data/rd_valid one cycle after the push edge. There is no same-cycle bypass.
  - rd_data holds its last value when empty; it is don't-care for checking.
- fill_level: next = current + push - pop. Updated at the same edge as the push/pop.
- Pointers wrap modulo DEPTH. A full/empty ambiguity must not occur; use an extra pointer bit or the level counter.
- Sequence check: applies on every dct_valid in CAPTURE, including dropped words.
  - If dct_count != exp_seq: set count_mismatch. If this is the first mismatch, also latch mismatch_seen=dct_count.
  - In all cases exp_seq <= dct_count+1, modulo 2^CNT_W. The counter resynchronises and wraps from 15 to 0 with the default CNT_W.
- Sticky flags (overflow, count_mismatch) and mismatch_seen clear only on reset.

Decomposition:
- Package hello_cpu_0_oci_pkg holds:
  - state enum {CAPTURE, DRAIN, DONE}, 2 bits.
  - default constants OCI_DCT_DATA_W=30, OCI_DCT_CNT_W=4.
- One sub-module, hello_cpu_0_oci_trace_fifo: parametrised (DATA_W, DEPTH) synchronous show-ahead FIFO with push, pop, full, empty and level outputs.
- The top level holds the FSM, drop/overflow logic and the sequence checker.

Test Plan:
- Reset with dct_valid=1 held -> all outputs 0. After release, 3 words 0x1,0x2,0x3 with counts 0,1,2 -> fill_level=3, count_mismatch=0. Popping yields 0x1,0x2,0x3 in order.
- 17 consecutive words with counts 0..15,0 and rd_ready=0, DEPTH=16 -> fill_level=16, overflow=1, drop_count=1, count_mismatch=0 (count wraps 15 to 0 cleanly).
- FIFO full, rd_ready=1 and dct_valid=1 in the same cycle -> push accepted, drop_count unchanged, fill_level stays 16.
- Counts 0,1,3,7 -> count_mismatch=1 after the count-3 word, mismatch_seen=3 (not 7), exp_seq=8 after the last word.
- 4 words buffered, test_ending=1 with dct_valid=1 -> 5 entries. Later dct_valid ignored. rd_ready=1 drains 5 words, and test_has_ended rises at the edge after the 5th pop.
- reset_n=0 during DRAIN with 3 entries -> next cycle fill_level=0, rd_valid=0, test_has_ended=0, state CAPTURE. A new word with count 0 shows no mismatch.

Source files
------------

// File: rtl/hello_cpu_0_oci_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hello_cpu_0_oci_pkg : shared types and default widths for the OCI monitor
// Revision: 1.0
// ---------------------------------------------------------------------------
package hello_cpu_0_oci_pkg;

   localparam int OCI_DCT_DATA_W = 30;
   localparam int OCI_DCT_CNT_W  = 4;

   typedef enum logic [1:0] {
      CAPTURE = 2'd0,
      DRAIN   = 2'd1,
      DONE    = 2'd2
   } oci_state_t;

endpackage
`default_nettype wire

// File: rtl/hello_cpu_0_oci_trace_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hello_cpu_0_oci_trace_fifo : synchronous show-ahead FIFO with level output
// Revision: 1.0
// ---------------------------------------------------------------------------
module hello_cpu_0_oci_trace_fifo #(
   parameter  int DATA_W = 30,
   parameter  int DEPTH  = 16,
   localparam int LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty,
   output logic [LVL_W-1:0]  level
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic [DATA_W-1:0] r_last;
   logic              w_pop;
   logic              w_push;

   assign empty  = (r_level == '0);
   assign full   = (r_level == LVL_W'(DEPTH));
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);
   assign level  = r_level;

   // Level counter resolves full/empty, so pointers need no extra wrap bit.
   assign pop_data = empty ? r_last : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (reset_n && w_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_last   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            r_last   <= r_mem[r_rd_ptr];
         end
         r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
      end
   end

endmodule
`default_nettype wire

// File: rtl/hello_cpu_0_oci_trace_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hello_cpu_0_oci_trace_monitor : DCT capture FIFO, sequence checker, drain FSM
// Revision: 1.0
// ---------------------------------------------------------------------------
module hello_cpu_0_oci_trace_monitor
   import hello_cpu_0_oci_pkg::*;
#(
   parameter  int DATA_W = OCI_DCT_DATA_W,
   parameter  int CNT_W  = OCI_DCT_CNT_W,
   parameter  int DEPTH  = 16,
   parameter  int DROP_W = 8,
   localparam int LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] dct_buffer,
   input  logic [CNT_W-1:0]  dct_count,
   input  logic              dct_valid,
   input  logic              test_ending,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [LVL_W-1:0]  fill_level,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_count,
   output logic              count_mismatch,
   output logic [CNT_W-1:0]  mismatch_seen,
   output logic              test_has_ended
);

   oci_state_t        r_state;
   oci_state_t        w_state_next;
   logic              r_ended;
   logic              r_overflow;
   logic [DROP_W-1:0] r_drop_count;
   logic              r_mismatch;
   logic [CNT_W-1:0]  r_mismatch_seen;
   logic [CNT_W-1:0]  r_exp_seq;
   logic              w_full;
   logic              w_empty;
   logic              w_pop;
   logic              w_capture_valid;
   logic              w_push;
   logic              w_drop;

   assign w_pop           = rd_ready && !w_empty;
   assign w_capture_valid = dct_valid && (r_state == CAPTURE);
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign w_push          = w_capture_valid && (!w_full || w_pop);
   assign w_drop          = w_capture_valid && !w_push;

   hello_cpu_0_oci_trace_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (w_push),
      .push_data (dct_buffer),
      .pop       (w_pop),
      .pop_data  (rd_data),
      .full      (w_full),
      .empty     (w_empty),
      .level     (fill_level)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         CAPTURE: if (test_ending) w_state_next = DRAIN;
         DRAIN:   if (w_empty || (fill_level == LVL_W'(1) && w_pop)) w_state_next = DONE;
         DONE:    w_state_next = DONE;
         default: w_state_next = CAPTURE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= CAPTURE;
         r_ended <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_ended <= (w_state_next == DONE);
      end
   end

   // Sequence check covers dropped words too; exp_seq always resyncs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_overflow      <= 1'b0;
         r_drop_count    <= '0;
         r_mismatch      <= 1'b0;
         r_mismatch_seen <= '0;
         r_exp_seq       <= '0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) begin
               r_drop_count <= r_drop_count + DROP_W'(1);
            end
         end
         if (w_capture_valid) begin
            if (dct_count != r_exp_seq) begin
               r_mismatch <= 1'b1;
               if (!r_mismatch) begin
                  r_mismatch_seen <= dct_count;
               end
            end
            r_exp_seq <= dct_count + CNT_W'(1);
         end
      end
   end

   assign rd_valid       = !w_empty;
   assign overflow       = r_overflow;
   assign drop_count     = r_drop_count;
   assign count_mismatch = r_mismatch;
   assign mismatch_seen  = r_mismatch_seen;
   assign test_has_ended = r_ended;

endmodule
`default_nettype wire

// File: tb/tb_hello_cpu_0_oci_trace_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hello_cpu_0_oci_trace_monitor : scoreboard bench for the OCI trace monitor
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_hello_cpu_0_oci_trace_monitor;

   localparam int DATA_W = 30;
   localparam int CNT_W  = 4;
   localparam int DEPTH  = 16;
   localparam int LVL_W  = 5;
   localparam int DROP_W = 8;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [DATA_W-1:0] dct_buffer;
   logic [CNT_W-1:0]  dct_count;
   logic              dct_valid;
   logic              test_ending;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [LVL_W-1:0]  fill_level;
   logic              overflow;
   logic [DROP_W-1:0] drop_count;
   logic              count_mismatch;
   logic [CNT_W-1:0]  mismatch_seen;
   logic              test_has_ended;

   always #5 clk = ~clk;

   hello_cpu_0_oci_trace_monitor #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W),
      .DEPTH  (DEPTH),
      .DROP_W (DROP_W)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .dct_valid      (dct_valid),
      .test_ending    (test_ending),
      .rd_data        (rd_data),
      .rd_valid       (rd_valid),
      .rd_ready       (rd_ready),
      .fill_level     (fill_level),
      .overflow       (overflow),
      .drop_count     (drop_count),
      .count_mismatch (count_mismatch),
      .mismatch_seen  (mismatch_seen),
      .test_has_ended (test_has_ended)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: 0=capture, 1=drain, 2=done
   logic [DATA_W-1:0] sb_q[$];
   int                m_state;
   logic              m_ended, m_ovf, m_mis;
   logic [DROP_W-1:0] m_drop;
   logic [CNT_W-1:0]  m_exp, m_seen;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".fill_level"}, 64'(fill_level), 64'(sb_q.size()));
      check({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
      check({tag, ".drop_count"}, 64'(drop_count), 64'(m_drop));
      check({tag, ".count_mismatch"}, 64'(count_mismatch), 64'(m_mis));
      check({tag, ".mismatch_seen"}, 64'(mismatch_seen), 64'(m_seen));
      check({tag, ".test_has_ended"}, 64'(test_has_ended), 64'(m_ended));
   endtask

   // Advance one clock: model the edge from current inputs, then sample after it.
   task automatic cycle();
      logic              do_pop, cap, do_push;
      logic [DATA_W-1:0] head;
      if (reset_n) begin
         check("rd_valid", 64'(rd_valid), 64'(sb_q.size() != 0));
         do_pop = (sb_q.size() != 0) && rd_ready;
         if (do_pop) begin
            head = sb_q.pop_front();
            check("rd_data", 64'(rd_data), 64'(head));
         end
         cap     = dct_valid && (m_state == 0);
         do_push = cap && ((sb_q.size() < DEPTH) || do_pop);
         if (do_push) begin
            sb_q.push_back(dct_buffer);
         end else if (cap) begin
            m_ovf = 1'b1;
            if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
         end
         if (cap) begin
            if (dct_count != m_exp) begin
               if (!m_mis) m_seen = dct_count;
               m_mis = 1'b1;
            end
            m_exp = dct_count + 4'd1;
         end
         if (m_state == 0 && test_ending) m_state = 1;
         else if (m_state == 1 && sb_q.size() == 0) m_state = 2;
         m_ended = (m_state == 2);
      end else begin
         sb_q.delete();
         m_state = 0; m_ended = 0; m_ovf = 0; m_mis = 0;
         m_drop  = '0; m_exp = '0; m_seen = '0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DATA_W-1:0] data, input logic [CNT_W-1:0] cnt);
      dct_valid  = 1'b1;
      dct_buffer = data;
      dct_count  = cnt;
      cycle();
      dct_valid  = 1'b0;
   endtask

   task automatic do_reset();
      reset_n     = 1'b0;
      dct_valid   = 1'b0;
      test_ending = 1'b0;
      rd_ready    = 1'b0;
      cycle();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n     = 1'b0;
      dct_buffer  = 30'h3ABCDEF;
      dct_count   = 4'd5;
      dct_valid   = 1'b1;
      test_ending = 1'b0;
      rd_ready    = 1'b0;

      // Reset with dct_valid held high
      cycle();
      cycle();
      check("rst.rd_data", 64'(rd_data), 64'd0);
      check("rst.rd_valid", 64'(rd_valid), 64'd0);
      check("rst.fill_level", 64'(fill_level), 64'd0);
      check_all("rst");
      reset_n   = 1'b1;
      dct_valid = 1'b0;

      send(30'h1, 4'd0);
      send(30'h2, 4'd1);
      send(30'h3, 4'd2);
      check("three.fill_level", 64'(fill_level), 64'd3);
      check("three.count_mismatch", 64'(count_mismatch), 64'd0);
      rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      rd_ready = 1'b0;
      check_all("three_drained");

      // 17 words into a 16-deep FIFO with a clean 15->0 wrap
      do_reset();
      for (int i = 0; i < 17; i++) send(30'(100 + i), 4'(i));
      check("fill.fill_level", 64'(fill_level), 64'd16);
      check("fill.overflow", 64'(overflow), 64'd1);
      check("fill.drop_count", 64'(drop_count), 64'd1);
      check("fill.count_mismatch", 64'(count_mismatch), 64'd0);

      // Full with simultaneous pop: push accepted
      rd_ready = 1'b1;
      send(30'h200, 4'd1);
      rd_ready = 1'b0;
      check("fullpop.fill_level", 64'(fill_level), 64'd16);
      check("fullpop.drop_count", 64'(drop_count), 64'd1);
      check_all("fullpop");

      // Drop counter saturation
      for (int i = 0; i < 300; i++) send(30'(i), 4'(i + 2));
      check("sat.drop_count", 64'(drop_count), 64'hFF);
      check("sat.count_mismatch", 64'(count_mismatch), 64'd0);
      check_all("sat");

      // Sequence gaps: first mismatch latched
      do_reset();
      send(30'h10, 4'd0);
      send(30'h11, 4'd1);
      check("seq.before_gap", 64'(count_mismatch), 64'd0);
      send(30'h13, 4'd3);
      check("seq.mismatch", 64'(count_mismatch), 64'd1);
      check("seq.seen3", 64'(mismatch_seen), 64'd3);
      send(30'h17, 4'd7);
      check("seq.seen_first", 64'(mismatch_seen), 64'd3);
      send(30'h18, 4'd8);
      check_all("seq");

      // Drain sequence
      do_reset();
      for (int i = 0; i < 4; i++) send(30'(i + 50), 4'(i));
      test_ending = 1'b1;
      send(30'h99, 4'd4);
      test_ending = 1'b0;
      check("end.fill_level", 64'(fill_level), 64'd5);
      send(30'h77, 4'd5);
      send(30'h78, 4'd6);
      check("drainin.fill_level", 64'(fill_level), 64'd5);
      check("drainin.drop_count", 64'(drop_count), 64'd0);
      rd_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("drain.test_has_ended", 64'(test_has_ended), 64'(i == 4));
      end
      test_ending = 1'b1;
      cycle();
      cycle();
      test_ending = 1'b0;
      rd_ready    = 1'b0;
      check("done.test_has_ended", 64'(test_has_ended), 64'd1);
      check_all("done");

      // Reset in the middle of a drain
      do_reset();
      for (int i = 0; i < 3; i++) send(30'(i + 7), 4'(i));
      test_ending = 1'b1;
      cycle();
      test_ending = 1'b0;
      check("predrn.fill_level", 64'(fill_level), 64'd3);
      reset_n = 1'b0;
      cycle();
      check("rstdrn.fill_level", 64'(fill_level), 64'd0);
      check("rstdrn.rd_valid", 64'(rd_valid), 64'd0);
      check("rstdrn.test_has_ended", 64'(test_has_ended), 64'd0);
      reset_n = 1'b1;
      send(30'h55, 4'd0);
      check("rstdrn.count_mismatch", 64'(count_mismatch), 64'd0);
      check("rstdrn.capture", 64'(fill_level), 64'd1);
      rd_ready = 1'b1;
      cycle();
      rd_ready = 1'b0;
      check_all("final");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
